// File: rtl/sn74_pkg.sv
// Shared definitions for the sn74 counter library: direction encoding and
// the terminal-count rule used by the up/down counters.
package sn74_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest counter the terminal-count helper supports.
  localparam int unsigned SN74_MAX_W = 32;

  // Terminal count: all-ones when counting up, zero when counting down.
  // Only the low 'width' bits of q take part in the decision.
  function automatic logic sn74_tc(input logic [SN74_MAX_W-1:0] q,
                                   input int unsigned           width,
                                   input logic                  d_u);
    logic [SN74_MAX_W-1:0] mask;
    mask = (SN74_MAX_W'(1) << width) - SN74_MAX_W'(1);
    if (d_u == DIR_DOWN) begin
      return (q & mask) == '0;
    end
    return (q & mask) == mask;
  endfunction

endpackage

// File: rtl/sn74xx191.sv
// Synchronous presettable up/down binary counter in the 74'191 style.
// Clear is asynchronous; load and count act on the rising clock edge.
// max_min and rco_n are combinational so stages can be cascaded by wiring
// rco_n of one stage to cten_n of the next on a shared clock.
module sn74xx191
  import sn74_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             cten_n,
  input  logic             d_u,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             max_min,
  output logic             rco_n
);

  logic [WIDTH-1:0] r_q;
  logic             w_tc;

  // Counter state: async clear, then load beats count, otherwise hold.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q <= '0;
    end else if (!load_n) begin
      r_q <= d;
    end else if (!cten_n) begin
      if (d_u == DIR_DOWN) begin
        r_q <= r_q - WIDTH'(1);
      end else begin
        r_q <= r_q + WIDTH'(1);
      end
    end
  end

  // Terminal count follows q and d_u directly, so a direction change shows
  // up in the same cycle; it is deliberately not gated by the enable.
  assign w_tc    = sn74_tc(SN74_MAX_W'(r_q), WIDTH, d_u);

  assign q       = r_q;
  assign max_min = w_tc;
  // Low for the whole cycle before the wrap edge, enabling the next stage.
  assign rco_n   = ~(w_tc & ~cten_n);

endmodule

// File: tb/tb_sn74xx191.sv
// Bench for sn74xx191: two 4-bit stages cascaded into an 8-bit counter,
// checked against an integer model of the 8-bit count.
module tb_sn74xx191;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       load_n;
  logic       cten_n;
  logic       d_u;
  logic [7:0] d;
  logic [3:0] q0, q1;
  logic       mm0, mm1, rco0_n, rco1_n;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt    = 0;   // model: 8-bit count as a plain integer 0..255

  always #5 clk = ~clk;

  sn74xx191 #(.WIDTH(4)) u_lo (
    .clk(clk), .clr_n(clr_n), .load_n(load_n), .cten_n(cten_n), .d_u(d_u),
    .d(d[3:0]), .q(q0), .max_min(mm0), .rco_n(rco0_n)
  );

  sn74xx191 #(.WIDTH(4)) u_hi (
    .clk(clk), .clr_n(clr_n), .load_n(load_n), .cten_n(rco0_n), .d_u(d_u),
    .d(d[7:4]), .q(q1), .max_min(mm1), .rco_n(rco1_n)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Compare every output against the model's current count and inputs.
  task automatic check_all(input string tag);
    int lo, hi, e_mm0, e_mm1, e_rco0, e_rco1;
    lo     = cnt % 16;
    hi     = cnt / 16;
    e_mm0  = d_u ? int'(lo == 0) : int'(lo == 15);
    e_mm1  = d_u ? int'(hi == 0) : int'(hi == 15);
    e_rco0 = (e_mm0 != 0 && !cten_n) ? 0 : 1;
    e_rco1 = (!cten_n && cnt == (d_u ? 0 : 255)) ? 0 : 1;
    chk({tag, "_q"},      int'({q1, q0}), cnt);
    chk({tag, "_mm0"},    int'(mm0),      e_mm0);
    chk({tag, "_rco0"},   int'(rco0_n),   e_rco0);
    chk({tag, "_mm1"},    int'(mm1),      e_mm1);
    chk({tag, "_rco1"},   int'(rco1_n),   e_rco1);
  endtask

  // One rising edge; the model applies the same edge, then outputs settle.
  task automatic tick();
    @(posedge clk);
    if (!clr_n)       cnt = 0;
    else if (!load_n) cnt = int'(d);
    else if (!cten_n) cnt = d_u ? (cnt + 255) % 256 : (cnt + 1) % 256;
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    load_n = 1'b0; d = v;
    tick();
    load_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0; load_n = 1'b1; cten_n = 1'b1; d_u = 1'b0; d = '0;
    #2;
    check_all("rst_up");
    d_u = 1'b1; cten_n = 1'b0; #1;
    check_all("rst_dn");
    d_u = 1'b0; cten_n = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;

    // Async clear mid-count, no clock edge needed.
    load(8'h06);
    check_all("t1_loaded");
    @(negedge clk);
    clr_n = 1'b0; cnt = 0; #1;
    check_all("t1_clr");
    #2 clr_n = 1'b1;
    cten_n = 1'b0; d_u = 1'b0;
    tick();
    check_all("t1_first");

    // Count up 17 edges from 0.
    load(8'h00);
    for (int i = 0; i < 17; i++) begin
      tick();
      check_all($sformatf("t2_up%0d", i));
    end

    // Load 3, count down through the wrap.
    d_u = 1'b1;
    load(8'h03);
    check_all("t3_ld");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("t3_dn%0d", i));
    end

    // Disabled: hold while direction toggles.
    cten_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_u = ~d_u; #1;
      check_all($sformatf("t4_dir%0d", i));
      tick();
      check_all($sformatf("t4_hold%0d", i));
    end

    // Load beats count on the same edge.
    cten_n = 1'b0; d_u = 1'b0;
    load(8'h0A);
    check_all("t5_ld");
    for (int i = 0; i < 5; i++) tick();
    check_all("t5_at15");
    chk("t5_mm_hi", int'(mm0), 1);
    d_u = 1'b1; #1;
    chk("t5_mm_flip", int'(mm0), 0);
    check_all("t5_flip");

    // Cascade behaviour.
    d_u = 1'b0; cten_n = 1'b0;
    load(8'h0E);
    tick(); check_all("t6_0f");
    tick(); check_all("t6_10");
    load(8'hFF);
    check_all("t6_ff");
    tick(); check_all("t6_wrap");
    d_u = 1'b1; #1;
    check_all("t6_dn_pre");
    tick(); check_all("t6_dn_ff");

    // Randomised traffic with occasional loads and async clears.
    for (int i = 0; i < 300; i++) begin
      load_n = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      cten_n = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      d_u    = ($urandom_range(0, 7) == 0) ? ~d_u : d_u;
      d      = 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        clr_n = 1'b0; cnt = 0; #1;
        check_all("rnd_clr");
        #2 clr_n = 1'b1;
      end
      tick();
      check_all("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
